// File: rtl/mfp_pkg.sv
// mfp_pkg: shared widths and saturation helper for the MFP MAC datapath
package mfp_pkg;
  localparam int MFP_SATCNT_W = 16;
  function automatic longint mfp_max_pos(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction
endpackage

// File: rtl/mfp_round_sat.sv
// mfp_round_sat: drop FracDrop LSBs (floor or round half-up) and clamp symmetrically to OutW
module mfp_round_sat
  import mfp_pkg::*;
#(
  parameter int InW      = 24,
  parameter int FracDrop = 7,
  parameter int OutW     = 8,
  parameter int isFloor  = 1
) (
  input  logic [InW-1:0]  acc_in,
  output logic [OutW-1:0] value,
  output logic            sat
);
  localparam int W = InW + 1;
  localparam logic signed [W-1:0] RND   = isFloor != 0 ? '0 : W'(1) << (FracDrop - 1);
  localparam logic signed [W-1:0] MAX_V = W'(mfp_max_pos(OutW));
  localparam logic signed [W-1:0] MIN_V = -MAX_V;
  logic signed [W-1:0] shd;
  logic hi, lo;
  // one extra bit keeps the rounding add from wrapping before the shift
  always_comb begin
    shd   = (W'($signed(acc_in)) + RND) >>> FracDrop;
    hi    = shd > MAX_V;
    lo    = shd < MIN_V;
    sat   = hi | lo;
    value = hi ? MAX_V[OutW-1:0] : lo ? MIN_V[OutW-1:0] : shd[OutW-1:0];
  end
endmodule

// File: rtl/mfp_mac_accum.sv
// mfp_mac_accum: TapN-tap signed MAC with round/saturate output; MFP_MAC_SATCNT_EN enables sat_cnt
module mfp_mac_accum
  import mfp_pkg::*;
#(
  parameter int InW      = 8,
  parameter int CoefW    = 8,
  parameter int TapN     = 3,
  parameter int AccW     = 24,
  parameter int FracDrop = 7,
  parameter int OutW     = 8,
  parameter int isFloor  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [InW-1:0]          in_data,
  input  logic [CoefW-1:0]        in_coef,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OutW-1:0]         out_data,
  output logic                    out_sat,
  output logic [MFP_SATCNT_W-1:0] sat_cnt
);
  localparam int PW = InW + CoefW;
  localparam int TW = TapN > 1 ? $clog2(TapN) : 1;
  logic [TW-1:0] tap_q, tap_d;
  logic p_valid_q, p_valid_d, p_last_q, p_last_d, p_first_q, p_first_d;
  logic signed [PW-1:0] p_prod_q, p_prod_d;
  logic signed [AccW-1:0] acc_q, acc_d, sum;
  logic out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic [OutW-1:0] out_data_q, out_data_d, rs_value;
  logic advance, accept, is_last, load, rs_sat;
  // handshake, tap tracking, product stage and accumulate/output stage
  always_comb begin
    advance     = en & ~(out_valid_q & ~out_ready);
    accept      = in_valid & advance;
    is_last     = tap_q == TW'(TapN - 1);
    tap_d       = accept ? (is_last ? '0 : tap_q + TW'(1)) : tap_q;
    p_valid_d   = advance ? accept : p_valid_q;
    p_prod_d    = accept ? PW'($signed(in_data)) * PW'($signed(in_coef)) : p_prod_q;
    p_last_d    = accept ? is_last : p_last_q;
    p_first_d   = accept ? tap_q == '0 : p_first_q;
    sum         = p_first_q ? AccW'(p_prod_q) : acc_q + AccW'(p_prod_q);
    acc_d       = advance & p_valid_q ? sum : acc_q;
    load        = advance & p_valid_q & p_last_q;
    out_valid_d = load | (out_valid_q & ~(en & out_ready));
    out_data_d  = load ? rs_value : out_data_q;
    out_sat_d   = load ? rs_sat : out_sat_q;
  end
  // pipeline registers; reset discards any partial group
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q       <= '0;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_first_q   <= 1'b0;
      p_prod_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      tap_q       <= tap_d;
      p_valid_q   <= p_valid_d;
      p_last_q    <= p_last_d;
      p_first_q   <= p_first_d;
      p_prod_q    <= p_prod_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end
  mfp_round_sat #(.InW(AccW), .FracDrop(FracDrop), .OutW(OutW), .isFloor(isFloor)) u_rs (
    .acc_in(sum),
    .value (rs_value),
    .sat   (rs_sat)
  );
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
`ifdef MFP_MAC_SATCNT_EN
  logic [MFP_SATCNT_W-1:0] sat_cnt_q, sat_cnt_d;
  // count clamped results, sticking at all-ones
  always_comb sat_cnt_d = (load & rs_sat & ~&sat_cnt_q) ? sat_cnt_q + MFP_SATCNT_W'(1) : sat_cnt_q;
  // saturation counter register
  always_ff @(posedge clk) begin
    if (rst) sat_cnt_q <= '0;
    else sat_cnt_q <= sat_cnt_d;
  end
  assign sat_cnt = sat_cnt_q;
`else
  assign sat_cnt = '0;
`endif
endmodule

// File: tb/tb_mfp_mac_accum.sv
// tb_mfp_mac_accum: scoreboard bench driving a floor and a round-half-up instance in lockstep
module tb_mfp_mac_accum;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = '0, in_coef = '0;
  logic in_ready0, out_valid0, out_sat0, in_ready1, out_valid1, out_sat1;
  logic [7:0] out_data0, out_data1;
  logic [15:0] sat_cnt0, sat_cnt1;
  int n_chk = 0, n_fail = 0, n_out = 0, grp_sum = 0, grp_taps = 0;
  typedef struct {int d0; bit s0; int d1; bit s1;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  mfp_mac_accum dut0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_coef(in_coef), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_sat(out_sat0), .sat_cnt(sat_cnt0)
  );
  mfp_mac_accum #(.isFloor(0)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_coef(in_coef), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_sat(out_sat1), .sat_cnt(sat_cnt1)
  );

  function automatic int rs_model(input int s, input bit fl, output bit sat);
    int v;
    v = (fl ? s : s + 64) >>> 7;
    sat = 1'b0;
    if (v > 127) begin v = 127; sat = 1'b1; end
    else if (v < -127) begin v = -127; sat = 1'b1; end
    return v;
  endfunction

  // scoreboard: accepted inputs build expected results, transfers pop and compare
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      grp_sum = 0;
      grp_taps = 0;
    end else begin
      if (en && out_valid0 && out_ready) begin
        n_out++;
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got data %0d with empty queue", $signed(out_data0));
        end else begin
          e = q.pop_front();
          if ($signed(out_data0) !== e.d0 || out_sat0 !== e.s0 || $signed(out_data1) !== e.d1 ||
              out_sat1 !== e.s1 || out_valid1 !== 1'b1) begin
            n_fail++;
            $display("FAIL result: got floor %0d/%0b round %0d/%0b v1=%0b, expected floor %0d/%0b round %0d/%0b",
                     $signed(out_data0), out_sat0, $signed(out_data1), out_sat1, out_valid1, e.d0, e.s0, e.d1, e.s1);
          end
        end
      end
      if (in_valid && in_ready0) begin
        grp_sum += $signed(in_data) * $signed(in_coef);
        grp_taps++;
        if (grp_taps == 3) begin
          e.d0 = rs_model(grp_sum, 1'b1, e.s0);
          e.d1 = rs_model(grp_sum, 1'b0, e.s1);
          q.push_back(e);
          grp_sum = 0;
          grp_taps = 0;
        end
      end
    end
  end

  task automatic send(input int d, input int c);
    int t = 0;
    in_valid = 1'b1;
    in_data = 8'(d);
    in_coef = 8'(c);
    do begin @(negedge clk); t++; end while (!(in_ready0 && en) && t < 200);
    if (t >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({out_valid0, out_data0, out_sat0, sat_cnt0, in_ready0} !== {1'b0, 8'd0, 1'b0, 16'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b d=%0d s=%0b cnt=%0d rdy=%0b, required 0 0 0 0 1",
               out_valid0, out_data0, out_sat0, sat_cnt0, in_ready0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    repeat (3) send(64, 64);
    n_chk++;
    if (out_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: out_valid=%0b right after last accept, required 0", out_valid0);
    end
    @(posedge clk); #1;
    n_chk++;
    if (out_valid0 !== 1'b1 || out_data0 !== 8'd96 || out_sat0 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic: got v=%0b d=%0d s=%0b, required 1 96 0", out_valid0, out_data0, out_sat0);
    end
    drain();
  endtask

  task automatic test_round();
    send(64, 64); send(64, 64); send(1, 64);
    @(posedge clk); #1;
    n_chk++;
    if (out_data0 !== 8'd64 || out_data1 !== 8'd65) begin
      n_fail++;
      $display("FAIL round: got floor %0d round %0d, required 64 65", out_data0, out_data1);
    end
    drain();
  endtask

  task automatic test_sat();
    int exp_cnt;
    repeat (3) send(127, 127);
    repeat (3) send(-128, 127);
    drain();
`ifdef MFP_MAC_SATCNT_EN
    exp_cnt = 2;
`else
    exp_cnt = 0;
`endif
    n_chk++;
    if (int'(sat_cnt0) !== exp_cnt || int'(sat_cnt1) !== exp_cnt) begin
      n_fail++;
      $display("FAIL sat_cnt: got %0d/%0d, required %0d", sat_cnt0, sat_cnt1, exp_cnt);
    end
    n_chk++;
    if ($signed(out_data0) !== -127 || out_sat0 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_neg_hold: got %0d/%0b, required -127/1", $signed(out_data0), out_sat0);
    end
  endtask

  task automatic test_backpressure();
    int base = n_out;
    out_ready = 1'b0;
    fork
      begin
        for (int g = 0; g < 3; g++)
          for (int t = 0; t < 3; t++) send(g * 20 + t * 7 - 30, t * 11 + g - 9);
      end
      begin
        int w = 0;
        while (out_valid0 !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        @(negedge clk);
        n_chk++;
        if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_ready: got in_ready=%0b out_valid=%0b, required 0 1", in_ready0, out_valid0);
        end
        w = 0;
        while (n_out < base + 3 && w < 100) begin
          repeat (3) @(posedge clk);
          #1 out_ready = 1'b1;
          @(posedge clk);
          #1 out_ready = 1'b0;
          w++;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    n_chk++;
    if (n_out != base + 3) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results, required 3", n_out - base);
    end
  endtask

  task automatic test_rst_mid();
    send(50, 50); send(50, 50);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++;
    if (out_valid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_valid: got %0b, required 0", out_valid0);
    end
    repeat (3) send(10, 10);
    @(posedge clk); #1;
    n_chk++;
    if (out_valid0 !== 1'b1 || out_data0 !== 8'd2) begin
      n_fail++;
      $display("FAIL rst_mid: got v=%0b d=%0d, required 1 2", out_valid0, out_data0);
    end
    drain();
  endtask

  task automatic test_en_stall();
    send(20, 30); send(-15, 40);
    in_valid = 1'b1;
    in_data = 8'd25;
    in_coef = -8'sd12;
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_chk++;
      if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0) begin
        n_fail++;
        $display("FAIL en_hold: got in_ready=%0b out_valid=%0b, required 0 0", in_ready0, out_valid0);
      end
    end
    @(posedge clk); #1;
    en = 1'b1;
    send(25, -12);
    @(posedge clk); #1;
    n_chk++;
    if ($signed(out_data0) !== -3 || $signed(out_data1) !== -2) begin
      n_fail++;
      $display("FAIL en_result: got %0d/%0d, required -3/-2", $signed(out_data0), $signed(out_data1));
    end
    drain();
    send(20, 30); send(-15, 40); send(25, -12);
    @(posedge clk); #1;
    n_chk++;
    if ($signed(out_data0) !== -3 || $signed(out_data1) !== -2) begin
      n_fail++;
      $display("FAIL unstalled_result: got %0d/%0d, required -3/-2", $signed(out_data0), $signed(out_data1));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round();
    test_sat();
    test_backpressure();
    test_rst_mid();
    test_en_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mfp_mac_accum.md
MFP_MAC_ACCUM -- requirements
Module: mfp_mac_accum

Interface
REQ-001 SHALL have parameter InW, default 8: signed sample width.
REQ-002 SHALL have parameter CoefW, default 8: signed coefficient width.
REQ-003 SHALL have parameter TapN, default 3: products summed per output, TapN>=1.
REQ-004 SHALL have parameter AccW, default 24: signed accumulator width, AccW >= InW+CoefW+clog2(TapN).
REQ-005 SHALL have parameter FracDrop, default 7: LSBs removed from the sum before output, FracDrop>=1.
REQ-006 SHALL have parameter OutW, default 8: signed output width.
REQ-007 SHALL have parameter isFloor, default 1: 1 truncates toward minus infinity, 0 rounds half-up.
REQ-008 SHALL have ports clk (in, 1, rising-edge clock) and rst (in, 1, reset).
REQ-009 SHALL have ports en (in, 1, global stall/enable), in_valid (in, 1), in_ready (out, 1), in_data (in, InW), in_coef (in, CoefW).
REQ-010 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_data (out, OutW), out_sat (out, 1, result was clamped) and sat_cnt (out, 16).
REQ-011 SHALL use one clock, clk; rst SHALL be synchronous and active-high.

Function
REQ-012 SHALL define stall = out_valid & ~out_ready, advance = en & ~stall, and in_ready = advance.
REQ-013 SHALL accept an input on a rising edge with in_valid & in_ready.
REQ-014 SHALL compute each product as a full InW+CoefW-bit signed product, registered in stage P with p_valid and p_last.
REQ-015 SHALL hold a tap counter, 0..TapN-1, that increments per accepted input and wraps to 0 after TapN-1; the input accepted at count TapN-1 is marked last.
REQ-016 SHALL, in stage A on advance & p_valid, set acc to the sign-extended product when the tap is the first of a group, and to acc plus the product otherwise.
REQ-017 SHALL, on a last product, load out_data with round_sat(acc+product), set out_valid=1 and set out_sat; acc SHALL NOT wrap within AccW.
REQ-018 SHALL compute round_sat as: add 2^(FracDrop-1) when isFloor=0, arithmetic-shift right by FracDrop, then clamp to +/-(2^(OutW-1)-1); the clamp is symmetric and -2^(OutW-1) is never output.
REQ-019 SHALL clear out_valid on an edge with en & out_valid & out_ready, unless a new result loads on the same edge, in which case out_valid stays 1 with the new data.
REQ-020 SHALL have a latency of 2 clk edges with continuous advance: the last tap is accepted at edge k and out_valid=1 after edge k+1.
REQ-021 SHALL freeze all state when en=0: no accept, no output transfer, outputs held.
REQ-022 SHALL keep results in order with none dropped or duplicated under any backpressure pattern.

Reset
REQ-023 SHALL clear on rst: tap counter, acc, p_valid, p_last, out_valid, out_data, out_sat and sat_cnt to 0.
REQ-024 SHALL discard a partial group on reset mid-operation; the first input after rst is tap 0.
REQ-025 SHALL take rst priority over en and over every handshake.

Configuration
REQ-026 SHALL, with MFP_MAC_SATCNT_EN defined, increment sat_cnt on each result loaded with out_sat=1, saturating at 16'hFFFF.
REQ-027 SHALL, without MFP_MAC_SATCNT_EN, keep the sat_cnt port and tie it to 0, with no counter logic.

Structure
REQ-028 SHALL place MFP_SATCNT_W=16 and a max-positive-value function for a given width in shared package mfp_pkg.
REQ-029 SHALL implement rounding and clamping in one combinational sub-module, mfp_round_sat (parameters InW, FracDrop, OutW, isFloor), with outputs value and sat.

Verification
REQ-030 SHALL cover: defaults, en=1, out_ready=1, inputs (64,64)x3 -> sum 12288 -> out_data=96, out_sat=0, out_valid 1 cycle after the 3rd accept.
REQ-031 SHALL cover: inputs (64,64),(64,64),(1,64), sum 8256 -> out_data=64 with isFloor=1 and 65 with isFloor=0.
REQ-032 SHALL cover: (127,127)x3 -> out_data=127, out_sat=1; then (-128,127)x3 -> out_data=-127, out_sat=1; sat_cnt=2 with the macro and 0 without.
REQ-033 SHALL cover: out_ready=0 while 3 groups stream -> in_ready falls once out_valid=1; out_ready pulsed every 4 cycles -> all 3 results emerge in order with correct values.
REQ-034 SHALL cover: rst for 1 cycle after 2 taps of a group, then (10,10)x3 -> out_data=(300>>7)=2 and no stale sum.
REQ-035 SHALL cover: en=0 for 5 cycles mid-group with in_valid=1 -> no accept, state held; en restored -> group completes with a result identical to the unstalled run.
